// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multi-cycle load/store initiator between the MEM stage and a word-organised
// data memory using a req/ack handshake. Issues word reads and writes, performs
// read-modify-write for byte/halfword stores and extracts/extends sub-word loads.
//
// Optional feature macro: MEM_SIGN_EXT_EN
//   defined   -> lb/lh sign-extend the selected lane
//   undefined -> lb/lh zero-extend (same as lbu/lhu)
//
// Parameters:
//   AW       word-address width (2^AW words of 32 bits)
//   TIMEOUT  max cycles mem_req may wait for mem_ack before aborting with err
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               request strobe, sampled only in IDLE
//   Instruction[5:0]    load/store opcode
//   alu_out[31:0]       byte address
//   salida2[31:0]       store data
//   busy                high from the cycle after an accepted start through done
//   done                one-cycle completion pulse
//   err                 error flag, valid with done
//   data_out[31:0]      load result, updated only on a successful load
//   mem_req, mem_we     memory request / write enable
//   mem_addr[AW-1:0]    word address
//   mem_wdata[31:0]     write word
//   mem_rdata[31:0]     read word, valid with mem_ack on a read
//   mem_ack             completes the current request
module mem_access_ctrl #(
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [5:0]    Instruction,
    input  logic [31:0]   alu_out,
    input  logic [31:0]   salida2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   data_out,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

`ifdef MEM_SIGN_EXT_EN
    localparam logic SIGN_EXT_EN = 1'b1;
`else
    localparam logic SIGN_EXT_EN = 1'b0;
`endif

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       store;
        logic [1:0] size;
        logic       sgn;
    } dec_t;

    // Opcode decode: legality, direction, access size, and signedness of the load.
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        case (op)
            6'b100011: d = {1'b1, 1'b0, SZ_W, 1'b0}; // lw
            6'b100000: d = {1'b1, 1'b0, SZ_B, 1'b1}; // lb
            6'b100001: d = {1'b1, 1'b0, SZ_H, 1'b1}; // lh
            6'b100100: d = {1'b1, 1'b0, SZ_B, 1'b0}; // lbu
            6'b100101: d = {1'b1, 1'b0, SZ_H, 1'b0}; // lhu
            6'b101011: d = {1'b1, 1'b1, SZ_W, 1'b0}; // sw
            6'b101000: d = {1'b1, 1'b1, SZ_B, 1'b0}; // sb
            6'b101001: d = {1'b1, 1'b1, SZ_H, 1'b0}; // sh
            default:   d = {1'b0, 1'b0, SZ_B, 1'b0};
        endcase
        return d;
    endfunction

    // Pick the addressed little-endian lane out of a word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overlay the store lane onto the word just read; other bytes are preserved.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [15:0] sd,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = w;
        case (size)
            SZ_B: begin
                case (off)
                    2'b00:   r[7:0]   = sd[7:0];
                    2'b01:   r[15:8]  = sd[7:0];
                    2'b10:   r[23:16] = sd[7:0];
                    2'b11:   r[31:24] = sd[7:0];
                    default: r        = w;
                endcase
            end
            SZ_H: begin
                if (off[1]) begin
                    r[31:16] = sd;
                end else begin
                    r[15:0] = sd;
                end
            end
            default: r = w;
        endcase
        return r;
    endfunction

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [31:0]  data_out_q, data_out_d;
    logic         mem_req_q, mem_req_d;
    logic         mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         store_q, store_d;
    logic [1:0]   size_q, size_d;
    logic         sgn_q, sgn_d;
    logic [1:0]   off_q, off_d;
    logic [15:0]  sdata_q, sdata_d;

    dec_t          dec_in;
    logic          misalign;
    logic          out_of_range;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        dec_in = decode(Instruction);
        if (dec_in.size == SZ_H) begin
            misalign = alu_out[0];
        end else if (dec_in.size == SZ_W) begin
            misalign = (alu_out[1:0] != 2'b00);
        end else begin
            misalign = 1'b0;
        end
        // Any address bit above the word-index field is outside the memory.
        out_of_range = ((alu_out >> (AW + 2)) != 32'd0);
        cnt_inc      = cnt_q + CW'(1);
        timeout_hit  = (cnt_inc == CW'(TIMEOUT));

        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        data_out_d  = data_out_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        sdata_d     = sdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    store_d = dec_in.store;
                    size_d  = dec_in.size;
                    sgn_d   = dec_in.sgn & SIGN_EXT_EN;
                    off_d   = alu_out[1:0];
                    sdata_d = salida2[15:0];
                    if (!dec_in.legal || misalign || out_of_range) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (dec_in.store && (dec_in.size == SZ_W)) begin
                        state_d     = S_WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = alu_out[AW+1:2];
                        mem_wdata_d = salida2;
                        cnt_d       = '0;
                    end else begin
                        // Loads and sub-word stores both begin with a read.
                        state_d    = S_RD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = alu_out[AW+1:2];
                        cnt_d      = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    if (store_q) begin
                        // Request stays up across the RD->WR hand-over.
                        state_d     = S_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = store_merge(mem_rdata, sdata_q, off_q, size_q);
                        cnt_d       = '0;
                    end else begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        mem_req_d  = 1'b0;
                        data_out_d = load_extract(mem_rdata, off_q, size_q, sgn_q);
                    end
                end else if (timeout_hit) begin
                    // Abort: the write phase of an RMW is never issued.
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, registered outputs and latched request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            off_q       <= 2'd0;
            sdata_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            sdata_q     <= sdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign data_out  = data_out_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int AW      = 5;
    localparam int TIMEOUT = 15;

`ifdef MEM_SIGN_EXT_EN
    localparam bit SX = 1'b1;
`else
    localparam bit SX = 1'b0;
`endif

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    Instruction;
    logic [31:0]   alu_out;
    logic [31:0]   salida2;
    logic          busy, done, err;
    logic [31:0]   data_out;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic          mem_ack = 1'b0;

    mem_access_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .Instruction(Instruction),
        .alu_out(alu_out), .salida2(salida2), .busy(busy), .done(done),
        .err(err), .data_out(data_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0]   mem [0:(1<<AW)-1];
    bit            init_done = 1'b0;
    int            wcnt = 0;
    int            ws_cfg = 0;
    bit            ack_en = 1'b1;
    int            n_reads = 0, n_writes = 0, req_cycles = 0, stab_bad = 0;
    logic          ack_we = 1'b0;
    logic [AW-1:0] ack_addr = '0;
    logic [31:0]   ack_wdata = 32'd0;
    logic [31:0]   last_waddr = 32'd0, last_wdata = 32'd0;
    logic          prev_req = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_wdata = 32'd0;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA0B0C0D0 ^ 32'(i);
            mem[2] = 32'h11223344;
            mem[3] = 32'h8899AABB;
            init_done = 1'b1;
        end
        // An ack presented last negedge was consumed at the intervening posedge.
        if (mem_ack) begin
            if (ack_we) begin
                mem[ack_addr] = ack_wdata;
                n_writes++;
                last_waddr = 32'(ack_addr);
                last_wdata = ack_wdata;
            end else begin
                n_reads++;
            end
            wcnt = 0;
        end
        if (mem_req && prev_req && !mem_ack &&
            (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
            stab_bad++;
        prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
        if (mem_req) begin
            req_cycles++;
            if (ack_en && wcnt >= ws_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                ack_we    = mem_we;
                ack_addr  = mem_addr;
                ack_wdata = mem_wdata;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ws;
        int          exp_cyc;
        logic        exp_err;
        logic        is_load;
        logic [31:0] exp_data;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int ws, input int cyc, input logic e, input logic ld,
                       input logic [31:0] dat, input int rd, input int wr,
                       input logic [31:0] wa, input logic [31:0] ww);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.ws = ws; v.exp_cyc = cyc; v.exp_err = e;
        v.is_load = ld; v.exp_data = dat; v.exp_rd = rd; v.exp_wr = wr;
        v.exp_waddr = wa; v.exp_wword = ww;
        vq.push_back(v);
    endtask

    // Issue one request at a negedge (cycle 0) and wait for done; checks busy.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int ws, input bit ack_on,
                          input bit pulse, output int dcyc, output logic derr);
        int  cyc;
        bit  busy_bad;
        ws_cfg = ws;
        ack_en = ack_on;
        @(negedge clk);
        Instruction = op; alu_out = addr; salida2 = wd; start = 1'b1;
        cyc = 0; dcyc = -1; derr = 1'b0; busy_bad = 1'b0;
        while (dcyc < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = pulse ? (cyc % 2 == 1) : 1'b0;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                dcyc = cyc;
                derr = err;
            end
        end
        if (dcyc < 0) begin
            errors++;
            checks++;
            $display("FAIL %s no_done: got none within %0d cycles", tag, cyc);
        end
        chk({tag, " busy_during"}, {31'd0, busy_bad}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " after_done busy/done"}, {30'd0, busy, done}, 32'd0);
    endtask

    logic [31:0] last_data;
    int          dcyc, rd0, wr0, rq0;
    logic        derr;
    vec_t        v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; Instruction = 6'd0; alu_out = 32'd0; salida2 = 32'd0;

        //   op       addr          wdata          ws cyc err ld  data                              rd wr waddr  wword
        add(OP_LB,  32'h0000000E, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFFFF99 : 32'h00000099, 1, 0, 32'd0, 32'd0);
        add(OP_LBU, 32'h0000000E, 32'h0,         0, 2, 0, 1, 32'h00000099,                      1, 0, 32'd0, 32'd0);
        add(OP_LH,  32'h0000000E, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFF8899 : 32'h00008899, 1, 0, 32'd0, 32'd0);
        add(OP_LHU, 32'h0000000C, 32'h0,         0, 2, 0, 1, 32'h0000AABB,                      1, 0, 32'd0, 32'd0);
        add(OP_LW,  32'h0000000C, 32'h0,         2, 4, 0, 1, 32'h8899AABB,                      1, 0, 32'd0, 32'd0);
        add(OP_LB,  32'h0000000D, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFFFFAA : 32'h000000AA, 1, 0, 32'd0, 32'd0);
        add(OP_LB,  32'h0000000F, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFFFF88 : 32'h00000088, 1, 0, 32'd0, 32'd0);
        add(OP_LB,  32'h0000000C, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFFFFBB : 32'h000000BB, 1, 0, 32'd0, 32'd0);
        add(OP_SH,  32'h0000000A, 32'hDEADBEEF,  0, 3, 0, 0, 32'd0,                             1, 1, 32'd2, 32'hBEEF3344);
        add(OP_LW,  32'h00000008, 32'h0,         0, 2, 0, 1, 32'hBEEF3344,                      1, 0, 32'd0, 32'd0);
        add(OP_SW,  32'h00000005, 32'h12345678,  0, 1, 1, 0, 32'd0,                             0, 0, 32'd0, 32'd0);
        add(OP_LH,  32'h00000003, 32'h0,         0, 1, 1, 0, 32'd0,                             0, 0, 32'd0, 32'd0);
        add(OP_LW,  32'h00000080, 32'h0,         0, 1, 1, 0, 32'd0,                             0, 0, 32'd0, 32'd0);
        add(6'd0,   32'h00000010, 32'h0,         0, 1, 1, 0, 32'd0,                             0, 0, 32'd0, 32'd0);
        add(OP_LB,  32'hFFFFFFFC, 32'h0,         0, 1, 1, 0, 32'd0,                             0, 0, 32'd0, 32'd0);
        add(OP_SW,  32'h00000010, 32'hCAFEF00D,  1, 3, 0, 0, 32'd0,                             0, 1, 32'd4, 32'hCAFEF00D);
        add(OP_SB,  32'h00000013, 32'h1234565A,  0, 3, 0, 0, 32'd0,                             1, 1, 32'd4, 32'h5AFEF00D);
        add(OP_LW,  32'h00000010, 32'h0,         0, 2, 0, 1, 32'h5AFEF00D,                      1, 0, 32'd0, 32'd0);
        add(OP_SH,  32'h00000014, 32'h0000ABCD,  0, 3, 0, 0, 32'd0,                             1, 1, 32'd5, 32'hA0B0ABCD);
        add(OP_SB,  32'h00000016, 32'hFFFFFF11,  0, 3, 0, 0, 32'd0,                             1, 1, 32'd5, 32'hA011ABCD);
        add(OP_LH,  32'h0000007E, 32'h0,         0, 2, 0, 1, SX ? 32'hFFFFA0B0 : 32'h0000A0B0, 1, 0, 32'd0, 32'd0);
        add(OP_LW,  32'h0000007C, 32'h0,         1, 3, 0, 1, 32'hA0B0C0CF,                      1, 0, 32'd0, 32'd0);
        add(OP_LHU, 32'h00000002, 32'h0,         0, 2, 0, 1, 32'h0000A0B0,                      1, 0, 32'd0, 32'd0);

        repeat (2) @(negedge clk);
        chk("reset busy/done/err/req/we", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        chk("reset data_out", data_out, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        last_data = 32'd0;

        for (int i = 0; i < vq.size(); i++) begin
            string t;
            v = vq[i];
            t = $sformatf("vec%0d", i);
            rd0 = n_reads; wr0 = n_writes;
            run_op(t, v.op, v.addr, v.wd, v.ws, 1'b1, 1'b0, dcyc, derr);
            chk({t, " done_cycle"}, 32'(dcyc), 32'(v.exp_cyc));
            chk({t, " err"}, {31'd0, derr}, {31'd0, v.exp_err});
            if (v.is_load) last_data = v.exp_data;
            chk({t, " data_out"}, data_out, last_data);
            chk({t, " reads"}, 32'(n_reads - rd0), 32'(v.exp_rd));
            chk({t, " writes"}, 32'(n_writes - wr0), 32'(v.exp_wr));
            if (v.exp_wr != 0) begin
                chk({t, " write_addr"}, last_waddr, v.exp_waddr);
                chk({t, " write_data"}, last_wdata, v.exp_wword);
            end
        end

        // lw with no ack: request held exactly TIMEOUT cycles, then err.
        rd0 = n_reads; rq0 = req_cycles;
        run_op("timeout", OP_LW, 32'h00000004, 32'd0, 0, 1'b0, 1'b0, dcyc, derr);
        chk("timeout done_cycle", 32'(dcyc), 32'(TIMEOUT + 1));
        chk("timeout err", {31'd0, derr}, 32'd1);
        chk("timeout req_cycles", 32'(req_cycles - rq0), 32'(TIMEOUT));
        chk("timeout reads", 32'(n_reads - rd0), 32'd0);
        chk("timeout data_out held", data_out, last_data);

        // sb with 3 wait states per phase, start pulsing throughout busy.
        rd0 = n_reads; wr0 = n_writes;
        run_op("sb_wait", OP_SB, 32'h00000011, 32'h00000077, 3, 1'b1, 1'b1, dcyc, derr);
        chk("sb_wait done_cycle", 32'(dcyc), 32'd9);
        chk("sb_wait err", {31'd0, derr}, 32'd0);
        chk("sb_wait reads", 32'(n_reads - rd0), 32'd1);
        chk("sb_wait writes", 32'(n_writes - wr0), 32'd1);
        chk("sb_wait mem4", mem[4], 32'h5AFE770D);
        @(negedge clk);
        chk("sb_wait no_restart", {31'd0, mem_req}, 32'd0);

        // Reset asserted during the WR phase of sh.
        ws_cfg = 3; ack_en = 1'b1; wr0 = n_writes;
        @(negedge clk);
        Instruction = OP_SH; alu_out = 32'h00000008; salida2 = 32'h0000CAFE; start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_wr in_wr req/we", {30'd0, mem_req, mem_we}, 32'd3);
        reset = 1'b1;
        #1;
        chk("rst_wr immediate req/busy", {30'd0, mem_req, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr writes", 32'(n_writes - wr0), 32'd0);
        chk("rst_wr mem2", mem[2], 32'hBEEF3344);
        run_op("post_rst", OP_LW, 32'h00000008, 32'd0, 0, 1'b1, 1'b0, dcyc, derr);
        chk("post_rst done_cycle", 32'(dcyc), 32'd2);
        chk("post_rst err", {31'd0, derr}, 32'd0);
        chk("post_rst data_out", data_out, 32'hBEEF3344);

        chk("req_stability", 32'(stab_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
